// File: rtl/spi_reg_master.sv
// spi_reg_master: SPI mode-3 master that sends {rw, addr[6:0]} followed by a data byte.
// Define SPI_REG_MASTER_READBACK_EN to capture MISO during the data byte into o_rdata.
module spi_reg_master #(
    parameter int CLK_DIV    = 10,
    parameter int GAP_CYCLES = 20
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_rw,
    input  logic [6:0] i_addr,
    input  logic [7:0] i_wdata,
    input  logic       i_MISO,
    output logic       o_SCLK,
    output logic       o_SSEL,
    output logic       o_MOSI,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_rdata
);
    localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP1_LAST = CW'(GAP_CYCLES - 1);
    // The final gap cycle is the IDLE/done cycle, so GAP2 itself lasts one cycle less.
    localparam logic [CW-1:0] GAP2_LAST = CW'((GAP_CYCLES > 1) ? (GAP_CYCLES - 2) : 0);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        GAP1 = 3'd2,
        DATA = 3'd3,
        GAP2 = 3'd4
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [2:0]    bit_r, bit_s;
    logic [7:0]    tx_r, tx_s;
    logic [7:0]    wdata_r, wdata_s;
    logic          rw_r, rw_s;
    logic          sclk_r, sclk_s;
    logic          ssel_r, ssel_s;
    logic          mosi_r, mosi_s;
    logic          busy_r, busy_s;
    logic          done_r, done_s;
    logic          rise_s;
    logic          last_s;

    // State and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            bit_r   <= 3'd0;
            tx_r    <= 8'h00;
            wdata_r <= 8'h00;
            rw_r    <= 1'b0;
            sclk_r  <= 1'b1;
            ssel_r  <= 1'b1;
            mosi_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            bit_r   <= bit_s;
            tx_r    <= tx_s;
            wdata_r <= wdata_s;
            rw_r    <= rw_s;
            sclk_r  <= sclk_s;
            ssel_r  <= ssel_s;
            mosi_r  <= mosi_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        bit_s   = bit_r;
        tx_s    = tx_r;
        wdata_s = wdata_r;
        rw_s    = rw_r;
        sclk_s  = sclk_r;
        ssel_s  = ssel_r;
        mosi_s  = mosi_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        rise_s  = 1'b0;
        last_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_start) begin
                    state_s = CMD;
                    cnt_s   = {CW{1'b0}};
                    bit_s   = 3'd0;
                    tx_s    = {i_rw, i_addr};
                    wdata_s = i_wdata;
                    rw_s    = i_rw;
                    sclk_s  = 1'b0;
                    ssel_s  = 1'b0;
                    mosi_s  = i_rw;
                    busy_s  = 1'b1;
                end else begin
                    sclk_s  = 1'b1;
                    ssel_s  = 1'b1;
                    mosi_s  = 1'b0;
                    busy_s  = 1'b0;
                end
            end
            CMD, DATA: begin
                if (cnt_r != HALF_LAST) begin
                    cnt_s = cnt_r + CW'(1);
                end else begin
                    cnt_s = {CW{1'b0}};
                    if (!sclk_r) begin
                        sclk_s = 1'b1;
                        rise_s = (state_r == DATA);
                    end else if (bit_r != 3'd7) begin
                        bit_s  = bit_r + 3'd1;
                        sclk_s = 1'b0;
                        mosi_s = tx_r[6];
                        tx_s   = {tx_r[6:0], 1'b0};
                    end else begin
                        bit_s  = 3'd0;
                        sclk_s = 1'b1;
                        ssel_s = 1'b1;
                        mosi_s = 1'b0;
                        if (state_r == CMD) begin
                            state_s = GAP1;
                        end else begin
                            last_s = 1'b1;
                            if (GAP_CYCLES == 1) begin
                                state_s = IDLE;
                                busy_s  = 1'b0;
                                done_s  = 1'b1;
                            end else begin
                                state_s = GAP2;
                            end
                        end
                    end
                end
            end
            GAP1: begin
                if (cnt_r == GAP1_LAST) begin
                    state_s = DATA;
                    cnt_s   = {CW{1'b0}};
                    tx_s    = wdata_r;
                    sclk_s  = 1'b0;
                    ssel_s  = 1'b0;
                    mosi_s  = wdata_r[7];
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            GAP2: begin
                if (cnt_r == GAP2_LAST) begin
                    state_s = IDLE;
                    cnt_s   = {CW{1'b0}};
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CW{1'b0}};
                bit_s   = 3'd0;
                sclk_s  = 1'b1;
                ssel_s  = 1'b1;
                mosi_s  = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    assign o_SCLK = sclk_r;
    assign o_SSEL = ssel_r;
    assign o_MOSI = mosi_r;
    assign o_busy = busy_r;
    assign o_done = done_r;

`ifdef SPI_REG_MASTER_READBACK_EN
    logic [7:0] rx_r;
    logic [7:0] rdata_r;

    // MISO is taken on the edge that raises SCLK; the slave changed it a half-period earlier
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_r    <= 8'h00;
            rdata_r <= 8'h00;
        end else begin
            if (rise_s) begin
                rx_r <= {rx_r[6:0], i_MISO};
            end
            if (last_s && !rw_r) begin
                rdata_r <= rx_r;
            end
        end
    end

    assign o_rdata = rdata_r;
`else
    logic unused_s;
    assign unused_s = ^{i_MISO, rise_s, last_s, rw_r};
    assign o_rdata  = 8'h00;
`endif

endmodule

// File: tb/tb_spi_reg_master.sv
// Directed bench for spi_reg_master: a mode-3 slave model decodes frames and returns read data.
module tb_spi_reg_master;
    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_start = 1'b0;
    logic       i_rw = 1'b0;
    logic [6:0] i_addr = 7'h00;
    logic [7:0] i_wdata = 8'h00;
    logic       i_MISO = 1'b1;
    logic       o_SCLK, o_SSEL, o_MOSI, o_busy, o_done;
    logic [7:0] o_rdata;

`ifdef SPI_REG_MASTER_READBACK_EN
    localparam logic [7:0] RD_MISO = 8'h15;
    localparam logic [7:0] RD_EXP  = 8'h15;
`else
    localparam logic [7:0] RD_MISO = 8'hFF;
    localparam logic [7:0] RD_EXP  = 8'h00;
`endif

    spi_reg_master dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_rw    (i_rw),
        .i_addr  (i_addr),
        .i_wdata (i_wdata),
        .i_MISO  (i_MISO),
        .o_SCLK  (o_SCLK),
        .o_SSEL  (o_SSEL),
        .o_MOSI  (o_MOSI),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_rdata (o_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;
    int acc_edge = 0;

    // Slave / monitor state
    logic [7:0] bytes[$];
    int         ssel_lens[$];
    int         gaps[$];
    int         done_cnt = 0;
    int         done_lat = 0;
    logic       busy_at_done = 1'b1;
    logic [7:0] rdata_at_done = 8'h00;
    logic [7:0] miso_byte = 8'h00;
    logic [7:0] rx = 8'h00;
    int         nbits = 0;
    int         ssel_low = 0;
    int         gap_run = 0;
    logic [2:0] midx = 3'd0;
    logic       sclk_prev = 1'b1;
    logic       ssel_prev = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Mode-3 slave: sample MOSI when SCLK rises, drive MISO when SCLK falls
    always @(negedge clk) begin
        if (o_done) begin
            done_cnt++;
            done_lat      = edge_cnt + 1 - acc_edge;
            busy_at_done  = o_busy;
            rdata_at_done = o_rdata;
        end
        if (!o_SSEL) begin
            ssel_low++;
            if (o_SCLK && !sclk_prev) begin
                rx = {rx[6:0], o_MOSI};
                nbits++;
                if (nbits == 8) begin
                    bytes.push_back(rx);
                    nbits = 0;
                end
            end
            if (!o_SCLK && sclk_prev) begin
                i_MISO = miso_byte[3'd7 - midx];
                midx   = midx + 3'd1;
            end
        end else begin
            if (!ssel_prev) ssel_lens.push_back(ssel_low);
            ssel_low = 0;
            nbits    = 0;
            midx     = 3'd0;
        end
        if (!o_busy) gap_run = 0;
        else if (o_SSEL) gap_run++;
        else begin
            if (ssel_prev && gap_run != 0) gaps.push_back(gap_run);
            gap_run = 0;
        end
        sclk_prev = o_SCLK;
        ssel_prev = o_SSEL;
    end

    task automatic clear_mon();
        bytes.delete();
        ssel_lens.delete();
        gaps.delete();
        done_cnt = 0;
        done_lat = 0;
    endtask

    task automatic start_txn(input logic rw, input logic [6:0] addr, input logic [7:0] wd);
        @(negedge clk);
        i_rw = rw; i_addr = addr; i_wdata = wd; i_start = 1'b1;
        acc_edge = edge_cnt + 1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int start_cnt;
        int i;
        start_cnt = done_cnt;
        for (i = 0; i < 450 && done_cnt == start_cnt; i++) begin
            @(negedge clk);
            #1;
        end
        check_eq({tag, "_done_seen"}, 32'(done_cnt != start_cnt), 32'd1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_ssel", 32'(o_SSEL), 32'd1);
        check_eq("rst_sclk", 32'(o_SCLK), 32'd1);
        check_eq("rst_mosi", 32'(o_MOSI), 32'd0);
        check_eq("rst_busy", 32'(o_busy), 32'd0);
        check_eq("rst_done", 32'(o_done), 32'd0);
        check_eq("rst_rdata", 32'(o_rdata), 32'h00);
        i_rst = 1'b0;
        repeat (2) @(negedge clk);

        // Write 0x42 <- 0x02; inputs scrambled after acceptance must not matter
        clear_mon();
        miso_byte = 8'hA5;
        start_txn(1'b1, 7'h42, 8'h02);
        check_eq("wr_first_ssel", 32'(o_SSEL), 32'd0);
        check_eq("wr_first_sclk", 32'(o_SCLK), 32'd0);
        check_eq("wr_first_mosi", 32'(o_MOSI), 32'd1);
        check_eq("wr_first_busy", 32'(o_busy), 32'd1);
        i_rw = 1'b0; i_addr = 7'h7F; i_wdata = 8'hAA;
        wait_done("wr");
        check_eq("wr_nbytes", 32'(bytes.size()), 32'd2);
        check_eq("wr_cmd", 32'(bytes[0]), 32'hC2);
        check_eq("wr_data", 32'(bytes[1]), 32'h02);
        check_eq("wr_ssel_len0", 32'(ssel_lens[0]), 32'd160);
        check_eq("wr_ssel_len1", 32'(ssel_lens[1]), 32'd160);
        check_eq("wr_gap", 32'(gaps[0]), 32'd20);
        check_eq("wr_lat", 32'(done_lat), 32'd360);
        check_eq("wr_busy_at_done", 32'(busy_at_done), 32'd0);
        check_eq("wr_rdata", 32'(rdata_at_done), 32'h00);
        repeat (5) @(negedge clk);
        check_eq("wr_done_once", 32'(done_cnt), 32'd1);

        // Read 0x0A, slave returns RD_MISO
        clear_mon();
        miso_byte = RD_MISO;
        start_txn(1'b0, 7'h0A, 8'h5C);
        wait_done("rd");
        check_eq("rd_cmd", 32'(bytes[0]), 32'h0A);
        check_eq("rd_wdata_sent", 32'(bytes[1]), 32'h5C);
        check_eq("rd_lat", 32'(done_lat), 32'd360);
        check_eq("rd_rdata", 32'(rdata_at_done), 32'(RD_EXP));

        // Back-to-back writes; second start lands in the first done cycle
        clear_mon();
        miso_byte = 8'h00;
        start_txn(1'b1, 7'h70, 8'h04);
        wait_done("b2b1");
        i_rw = 1'b1; i_addr = 7'h73; i_wdata = 8'hFF; i_start = 1'b1;
        acc_edge = edge_cnt + 1;
        @(negedge clk);
        i_start = 1'b0;
        #1;
        check_eq("b2b_accepted", 32'(o_busy), 32'd1);
        wait_done("b2b2");
        check_eq("b2b_lat2", 32'(done_lat), 32'd360);
        check_eq("b2b_nbytes", 32'(bytes.size()), 32'd4);
        check_eq("b2b_cmd0", 32'(bytes[0]), 32'hF0);
        check_eq("b2b_data0", 32'(bytes[1]), 32'h04);
        check_eq("b2b_cmd1", 32'(bytes[2]), 32'hF3);
        check_eq("b2b_data1", 32'(bytes[3]), 32'hFF);
        check_eq("b2b_rdata_kept", 32'(o_rdata), 32'(RD_EXP));

        // i_start while busy is ignored
        clear_mon();
        start_txn(1'b1, 7'h11, 8'h5A);
        repeat (48) @(negedge clk);
        i_rw = 1'b0; i_addr = 7'h22; i_wdata = 8'h33; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        wait_done("busy");
        repeat (400) @(negedge clk);
        #1;
        check_eq("busy_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("busy_nbytes", 32'(bytes.size()), 32'd2);
        check_eq("busy_cmd", 32'(bytes[0]), 32'h91);
        check_eq("busy_data", 32'(bytes[1]), 32'h5A);

        // Reset mid command byte, then a normal read
        start_txn(1'b1, 7'h33, 8'h44);
        repeat (98) @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        check_eq("abort_ssel", 32'(o_SSEL), 32'd1);
        check_eq("abort_sclk", 32'(o_SCLK), 32'd1);
        check_eq("abort_mosi", 32'(o_MOSI), 32'd0);
        check_eq("abort_busy", 32'(o_busy), 32'd0);
        check_eq("abort_rdata", 32'(o_rdata), 32'h00);
        i_rst = 1'b0;
        repeat (3) @(negedge clk);
        clear_mon();
        miso_byte = 8'h15;
        start_txn(1'b0, 7'h02, 8'h00);
        wait_done("post");
        check_eq("post_cmd", 32'(bytes[0]), 32'h02);
        check_eq("post_lat", 32'(done_lat), 32'd360);
`ifdef SPI_REG_MASTER_READBACK_EN
        check_eq("post_rdata", 32'(rdata_at_done), 32'h15);
`else
        check_eq("post_rdata", 32'(rdata_at_done), 32'h00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
